conv1d_window: RTL and testbench

Sliding-window stage of the conv1d core, directly upstream of the tap data registers and the MAC. It accepts one input sample per cycle over a valid/ready stream and maintains the last K samples. Each time a full window is available at the configured stride, it presents all K samples in parallel on a registered valid/ready output. It also handles frame boundaries and flags frames that end without a complete final window.

---
 rtl/conv1d_pkg.sv | 14 +
 rtl/conv1d_tap_shift.sv | 29 ++
 rtl/conv1d_window.sv | 126 ++++++++++++
 tb/tb_conv1d_window.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_pkg.sv
// Shared definitions for the conv1d core: window FSM states and the
// default geometry used by the stages of the core.
package conv1d_pkg;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_N_BIT  = 8;
  localparam int DEF_K      = 3;
  localparam int DEF_STRIDE = 1;

endpackage

// File: rtl/conv1d_tap_shift.sv
// K-entry tap shift register. New samples enter at the top slice, the oldest
// sample sits in bits [N_BIT-1:0] and falls out on each shift.
module conv1d_tap_shift
  import conv1d_pkg::*;
#(
  parameter int N_BIT = DEF_N_BIT,
  parameter int K     = DEF_K
) (
  input  logic               clk,
  input  logic               i_clr,
  input  logic               i_shift_en,
  input  logic [N_BIT-1:0]   i_data,
  output logic [K*N_BIT-1:0] o_taps
);

  logic [K*N_BIT-1:0] r_taps;

  // Shift in one sample per enable; clear has priority.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_taps <= '0;
    end else if (i_shift_en) begin
      r_taps <= {i_data, r_taps[K*N_BIT-1:N_BIT]};
    end
  end

  assign o_taps = r_taps;

endmodule

// File: rtl/conv1d_window.sv
// Sliding-window stage: collects K samples, emits a parallel window every
// STRIDE samples once filled, tracks frame boundaries and flags frames whose
// last sample did not complete a window.
module conv1d_window
  import conv1d_pkg::*;
#(
  parameter int N_BIT  = DEF_N_BIT,
  parameter int K      = DEF_K,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [N_BIT-1:0]   s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [K*N_BIT-1:0] m_window,
  output logic               m_last,
  output logic               frame_err
);

  localparam int CNT_W = $clog2(K + 1);
  localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [CNT_W-1:0] K_CNT  = CNT_W'(K);
  localparam logic [PH_W-1:0]  PH_MAX = PH_W'(STRIDE - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_fill_cnt;
  logic [PH_W-1:0]    r_phase;
  logic               r_m_valid;
  logic               r_m_last;
  logic [K*N_BIT-1:0] r_m_window;
  logic               r_frame_err;

  logic               w_accept;
  logic               w_produce;
  logic [CNT_W-1:0]   w_fill_inc;
  logic [PH_W-1:0]    w_phase_inc;
  logic [K*N_BIT-1:0] w_taps;
  logic [K*N_BIT-1:0] w_window_next;
  logic               w_unused_oldest;

  // No skid buffer: input may only advance when the output slot is free
  // or being drained this cycle.
  assign s_ready  = !r_m_valid || m_ready;
  assign w_accept = s_valid && s_ready;

  conv1d_tap_shift #(
    .N_BIT (N_BIT),
    .K     (K)
  ) u_taps (
    .clk        (clk),
    .i_clr      (rst_n),
    .i_shift_en (w_accept),
    .i_data     (s_data),
    .o_taps     (w_taps)
  );

  // The emitted window is the register content after this accept's shift.
  assign w_window_next   = {s_data, w_taps[K*N_BIT-1:N_BIT]};
  assign w_unused_oldest = ^w_taps[N_BIT-1:0];

  // Decide whether the current accept completes a window.
  always_comb begin
    w_fill_inc  = (r_fill_cnt == K_CNT) ? r_fill_cnt : r_fill_cnt + 1'b1;
    w_phase_inc = (r_phase == PH_MAX) ? '0 : r_phase + 1'b1;
    w_produce   = 1'b0;
    if (w_accept) begin
      if (r_state == ST_FILL) begin
        w_produce = (w_fill_inc == K_CNT);
      end else begin
        w_produce = (w_phase_inc == '0);
      end
    end
  end

  // FSM, fill counter, stride phase and the frame-error pulse.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= ST_FILL;
      r_fill_cnt  <= '0;
      r_phase     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_accept && s_last && !w_produce;
      if (w_accept) begin
        if (s_last) begin
          r_state    <= ST_FILL;
          r_fill_cnt <= '0;
          r_phase    <= '0;
        end else if (r_state == ST_FILL) begin
          r_fill_cnt <= w_fill_inc;
          if (w_produce) begin
            r_state <= ST_RUN;
            r_phase <= '0;
          end
        end else begin
          r_phase <= w_phase_inc;
        end
      end
    end
  end

  // Output register: a new window overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_window <= '0;
    end else if (w_produce) begin
      r_m_valid  <= 1'b1;
      r_m_last   <= s_last;
      r_m_window <= w_window_next;
    end else if (m_ready) begin
      r_m_valid  <= 1'b0;
    end
  end

  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign m_window  = r_m_window;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_conv1d_window.sv
// Bench for conv1d_window: two instances (STRIDE=1 and STRIDE=2, K=3) share
// one input stream; a vector table drives the free-flowing frames and a
// queue carries the expected outputs to the cycle after each accept.
module tb_conv1d_window;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_ready;

  logic        s_ready1, m_valid1, m_last1, frame_err1;
  logic [23:0] m_window1;
  logic        s_ready2, m_valid2, m_last2, frame_err2;
  logic [23:0] m_window2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv1d_window #(.N_BIT(8), .K(3), .STRIDE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid1), .m_ready(m_ready),
    .m_window(m_window1), .m_last(m_last1), .frame_err(frame_err1)
  );

  conv1d_window #(.N_BIT(8), .K(3), .STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid2), .m_ready(m_ready),
    .m_window(m_window2), .m_last(m_last2), .frame_err(frame_err2)
  );

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic        v1;
    logic [23:0] w1;
    logic        l1;
    logic        e1;
    logic        v2;
    logic [23:0] w2;
    logic        l2;
    logic        e2;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  localparam logic [23:0] Z = 24'h0;

  function automatic logic [23:0] win(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return {c, b, a};
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic l,
                              input logic v1, input logic [23:0] w1, input logic l1, input logic e1,
                              input logic v2, input logic [23:0] w2, input logic l2, input logic e2);
    vec_t r;
    r.d = d; r.l = l;
    r.v1 = v1; r.w1 = w1; r.l1 = l1; r.e1 = e1;
    r.v2 = v2; r.w2 = w2; r.l2 = l2; r.e2 = e2;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t e);
    chk("s1_valid", 32'(m_valid1), 32'(e.v1));
    if (e.v1) begin
      chk("s1_window", 32'(m_window1), 32'(e.w1));
      chk("s1_last", 32'(m_last1), 32'(e.l1));
    end
    chk("s1_frame_err", 32'(frame_err1), 32'(e.e1));
    chk("s2_valid", 32'(m_valid2), 32'(e.v2));
    if (e.v2) begin
      chk("s2_window", 32'(m_window2), 32'(e.w2));
      chk("s2_last", 32'(m_last2), 32'(e.l2));
    end
    chk("s2_frame_err", 32'(frame_err2), 32'(e.e2));
  endtask

  logic [23:0] got_w[$];
  logic        got_l[$];
  logic [23:0] bp_exp[4];
  int          idx;
  int          stall;
  bit          acc;

  initial begin
    // Frame 1..5, last on 5
    tbl.push_back(mk(1, 0, 0, Z, 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(2, 0, 0, Z, 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(3, 0, 1, win(1,2,3), 0, 0, 1, win(1,2,3), 0, 0));
    tbl.push_back(mk(4, 0, 1, win(2,3,4), 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(5, 1, 1, win(3,4,5), 1, 0, 1, win(3,4,5), 1, 0));
    // Frame 1..7, last on 7
    tbl.push_back(mk(1, 0, 0, Z, 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(2, 0, 0, Z, 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(3, 0, 1, win(1,2,3), 0, 0, 1, win(1,2,3), 0, 0));
    tbl.push_back(mk(4, 0, 1, win(2,3,4), 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(5, 0, 1, win(3,4,5), 0, 0, 1, win(3,4,5), 0, 0));
    tbl.push_back(mk(6, 0, 1, win(4,5,6), 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(7, 1, 1, win(5,6,7), 1, 0, 1, win(5,6,7), 1, 0));
    // Frame 1..6, last on 6: stride-2 instance ends misaligned
    tbl.push_back(mk(1, 0, 0, Z, 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(2, 0, 0, Z, 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(3, 0, 1, win(1,2,3), 0, 0, 1, win(1,2,3), 0, 0));
    tbl.push_back(mk(4, 0, 1, win(2,3,4), 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(5, 0, 1, win(3,4,5), 0, 0, 1, win(3,4,5), 0, 0));
    tbl.push_back(mk(6, 1, 1, win(4,5,6), 1, 0, 0, Z, 0, 1));
    // Frame 10..12
    tbl.push_back(mk(10, 0, 0, Z, 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(11, 0, 0, Z, 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(12, 1, 1, win(10,11,12), 1, 0, 1, win(10,11,12), 1, 0));
    // Short frame 7, 8
    tbl.push_back(mk(7, 0, 0, Z, 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(8, 1, 0, Z, 0, 1, 0, Z, 0, 1));
    // Frame 1..3 right after the short frame
    tbl.push_back(mk(1, 0, 0, Z, 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(2, 0, 0, Z, 0, 0, 0, Z, 0, 0));
    tbl.push_back(mk(3, 1, 1, win(1,2,3), 1, 0, 1, win(1,2,3), 1, 0));

    rst_n = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_m_valid1", 32'(m_valid1), 0);
    chk("rst_m_last1", 32'(m_last1), 0);
    chk("rst_frame_err1", 32'(frame_err1), 0);
    chk("rst_m_window1", 32'(m_window1), 0);
    chk("rst_m_valid2", 32'(m_valid2), 0);
    chk("rst_m_window2", 32'(m_window2), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_s_ready1", 32'(s_ready1), 1);
    chk("rst_s_ready2", 32'(s_ready2), 1);

    // Table-driven frames through the scoreboard
    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      if (sb.size() > 0) check_vec(sb.pop_front());
      chk("tbl_s_ready1", 32'(s_ready1), 1);
      s_valid = 1'b1;
      s_data  = tbl[i].d;
      s_last  = tbl[i].l;
      sb.push_back(tbl[i]);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (sb.size() > 0) check_vec(sb.pop_front());
    chk("sb_drained", 32'(sb.size()), 0);
    @(negedge clk);
    chk("idle_valid1", 32'(m_valid1), 0);
    chk("idle_err2", 32'(frame_err2), 0);

    // Backpressure on the stride-1 instance: stall 4 cycles after first window
    bp_exp[0] = win(1,2,3); bp_exp[1] = win(2,3,4);
    bp_exp[2] = win(3,4,5); bp_exp[3] = win(4,5,6);
    idx = 0; stall = 0; acc = 1'b0;
    for (int cyc = 0; cyc < 40 && got_w.size() < 4; cyc++) begin
      @(negedge clk);
      if (acc) idx++;
      if (idx < 6) begin
        s_valid = 1'b1;
        s_data  = 8'(idx + 1);
        s_last  = (idx == 5);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      if (m_valid1 && stall < 4) begin
        m_ready = 1'b0;
        stall++;
      end else begin
        m_ready = 1'b1;
      end
      #1;
      if (!m_ready) begin
        chk("bp_s_ready_low", 32'(s_ready1), 0);
        chk("bp_hold_window", 32'(m_window1), 32'(win(1,2,3)));
      end
      acc = s_valid && s_ready1;
      if (m_valid1 && m_ready) begin
        got_w.push_back(m_window1);
        got_l.push_back(m_last1);
      end
    end
    chk("bp_window_count", 32'(got_w.size()), 4);
    chk("bp_stall_cycles", 32'(stall), 4);
    for (int i = 0; i < got_w.size() && i < 4; i++) begin
      chk("bp_window", 32'(got_w[i]), 32'(bp_exp[i]));
      chk("bp_last", 32'(got_l[i]), (i == 3) ? 32'd1 : 32'd0);
    end

    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;

    // Reset mid-frame with a window pending under backpressure
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'd5; s_last = 1'b0;
    @(negedge clk); s_data = 8'd6;
    @(negedge clk); s_data = 8'd7;
    @(negedge clk);
    s_valid = 1'b0;
    chk("pend_valid", 32'(m_valid1), 1);
    chk("pend_window", 32'(m_window1), 32'(win(5,6,7)));
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(m_valid1), 0);
    chk("midrst_err", 32'(frame_err1), 0);
    chk("midrst_window", 32'(m_window1), 0);
    rst_n = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("midrst_err_after", 32'(frame_err1), 0);
    s_valid = 1'b1; s_data = 8'd4; s_last = 1'b0;
    @(negedge clk);
    chk("restart_after4", 32'(m_valid1), 0);
    s_data = 8'd5;
    @(negedge clk);
    chk("restart_after5", 32'(m_valid1), 0);
    s_data = 8'd6; s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    chk("restart_valid", 32'(m_valid1), 1);
    chk("restart_window", 32'(m_window1), 32'(win(4,5,6)));
    chk("restart_last", 32'(m_last1), 1);
    @(negedge clk);
    chk("restart_err", 32'(frame_err1), 0);
    chk("restart_drained", 32'(m_valid1), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
